// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the processor FSM that drives it.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  // Returned on a read that was aborted by the timeout.
  localparam logic [31:0] POISON_WORD = 32'hDEADBEEF;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

endpackage

// File: rtl/dmem_timeout.sv
// Loadable down-counter; expired is high once the loaded budget has been consumed.
module dmem_timeout #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns MEM-stage strobes into a req/gnt/rvalid SRAM handshake
// with range checking, a per-phase timeout and a sticky error flag.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h10010000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           dAddress,
  input  logic [31:0]           dWriteData,
  output logic [31:0]           dReadData,
  output logic                  mem_busy,
  output logic                  mem_err,
  output logic [31:0]           err_addr,
  output logic                  sram_req,
  output logic                  sram_we,
  output logic [DEPTH_LOG2-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic                  sram_gnt,
  input  logic                  sram_rvalid,
  input  logic [31:0]           sram_rdata
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + (33'd4 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] BASE_WORD = BASE_ADDR[DEPTH_LOG2+1:2];

  dmem_state_t           state, state_nxt;
  logic [31:0]           addr_q, wdata_q, rdata_q, err_addr_q;
  logic [DEPTH_LOG2-1:0] word_q;
  logic                  we_q, err_q;
  logic                  accept, raise_err, rd_done, rd_poison, cnt_load, expired;
  logic                  addr_ok;
  logic [32:0]           addr33;
  logic [31:0]           err_src;

  // Low word-index bits of (dAddress - BASE_ADDR) depend only on the low bits of
  // both operands, so a narrow subtract is exact for any aligned in-range address.
  assign addr33  = {1'b0, dAddress};
  assign addr_ok = (dAddress[1:0] == 2'b00) && (addr33 >= LO_ADDR) && (addr33 < HI_ADDR);
  assign err_src = (state == ST_IDLE) ? dAddress : addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    raise_err = 1'b0;
    rd_done   = 1'b0;
    rd_poison = 1'b0;
    cnt_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (MemRead && MemWrite) begin
          raise_err = 1'b1;
        end else if (MemRead || MemWrite) begin
          if (addr_ok) begin
            accept    = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            raise_err = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (sram_gnt) begin
          if (we_q) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_load  = 1'b1;
            state_nxt = ST_RESP;
          end
        end else if (expired) begin
          raise_err = 1'b1;
          rd_poison = !we_q;
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (sram_rvalid) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (expired) begin
          raise_err = 1'b1;
          rd_poison = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= dAddress;
        word_q  <= dAddress[DEPTH_LOG2+1:2] - BASE_WORD;
        wdata_q <= dWriteData;
        we_q    <= MemWrite;
      end
      if (rd_done)   rdata_q <= sram_rdata;
      if (rd_poison) rdata_q <= POISON_WORD;
      if (raise_err) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= err_src;
      end
    end
  end

  dmem_timeout #(.WIDTH(TW)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (state != ST_IDLE),
    .load_val (TW'(TIMEOUT - 1)),
    .expired  (expired)
  );

  assign dReadData  = rdata_q;
  assign mem_busy   = (state != ST_IDLE);
  assign mem_err    = err_q;
  assign err_addr   = err_addr_q;
  assign sram_req   = (state == ST_REQ);
  assign sram_we    = (state == ST_REQ) && we_q;
  assign sram_addr  = word_q;
  assign sram_wdata = wdata_q;

endmodule
